// File: rtl/param_serializer.sv
// Parallel-to-serial shifter for the UART TX path: variable frame length,
// selectable bit order, even parity computed at load, one-cycle done pulse.
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  msb_first,
  input  logic                  load,
  input  logic                  enable,
  output logic                  data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  parity_bit
);

  // Handshake: load is accepted only while busy=0 (IDLE); enable advances one
  // bit only while busy=1 (SHIFT). The consumer samples data_out on the same
  // edge where it asserts enable. busy is the FSM state itself.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic                  state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      len_q;
  logic                  order_q;
  logic                  parity_q;
  logic                  done_q;

  logic [LEN_W-1:0]      eff_len;
  logic                  load_parity;
  logic [LEN_W-1:0]      bit_idx;
  logic                  data_out_c;

  always_comb begin
    eff_len = data_len;
    if (data_len == '0 || data_len > LEN_W'(DATA_WIDTH))
      eff_len = LEN_W'(DATA_WIDTH);
  end

  // Only the low eff_len bits of data_in contribute to parity.
  always_comb begin
    load_parity = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) < eff_len)
        load_parity = load_parity ^ data_in[i];
    end
  end

  always_comb begin
    bit_idx = cnt;
    if (order_q)
      bit_idx = len_q - LEN_W'(1) - cnt;
  end

  // Mux by comparison rather than direct indexing keeps the index width clean.
  always_comb begin
    data_out_c = 1'b0;
    if (state == ST_SHIFT) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (LEN_W'(i) == bit_idx)
          data_out_c = shreg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      len_q    <= '0;
      order_q  <= 1'b0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg    <= data_in;
            len_q    <= eff_len;
            order_q  <= msb_first;
            cnt      <= '0;
            parity_q <= load_parity;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (enable) begin
            if (cnt == len_q - LEN_W'(1)) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = data_out_c;
  assign busy       = state;
  assign done       = done_q;
  assign parity_bit = parity_q;

endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer: directed scenarios plus randomized
// frames compared against a bit-queue reference model.
module tb_param_serializer;

  localparam int DW = 8;
  localparam int LW = $clog2(DW + 1);

  logic          clk_tb;
  logic          rst;
  logic [DW-1:0] data_in;
  logic [LW-1:0] data_len;
  logic          msb_first;
  logic          load;
  logic          enable;
  logic          data_out;
  logic          busy;
  logic          done;
  logic          parity_bit;

  int checks;
  int errors;

  logic [0:0] exp_q[$];
  logic       exp_par;

  param_serializer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk       (clk_tb),
    .rst       (rst),
    .data_in   (data_in),
    .data_len  (data_len),
    .msb_first (msb_first),
    .load      (load),
    .enable    (enable),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .parity_bit(parity_bit)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  // Reference model: list the bits in transmit order, parity = odd count of ones.
  task automatic build_model(input logic [DW-1:0] w, input int len, input logic msb);
    int eff;
    int ones;
    logic [DW-1:0] wv;
    wv = w;
    eff = (len == 0 || len > DW) ? DW : len;
    exp_q.delete();
    ones = 0;
    for (int k = 0; k < eff; k++) begin
      if (msb) exp_q.push_back(wv[eff - 1 - k]);
      else     exp_q.push_back(wv[k]);
      if (wv[k]) ones++;
    end
    exp_par = (ones % 2) == 1;
  endtask

  task automatic start_frame(input logic [DW-1:0] w, input int len, input logic msb);
    data_in   = w;
    data_len  = LW'(len);
    msb_first = msb;
    load      = 1'b1;
    enable    = 1'($urandom_range(0, 1));
    build_model(w, len, msb);
    tick();
    load = 1'b0;
  endtask

  // mode 0: enable always high, 1: random, 2: pattern 1,0,0. noise drives
  // spurious loads with random data, which must be ignored while busy.
  task automatic shift_frame(input int mode, input bit noise);
    int c;
    logic en;
    c = 0;
    while (exp_q.size() > 0) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL shift_status busy=%b done=%b exp busy=1 done=0", busy, done);
      end
      checks++;
      if (data_out !== exp_q[0]) begin
        errors++;
        $display("FAIL shift_bit got %b exp %b (remaining %0d)", data_out, exp_q[0], exp_q.size());
      end
      checks++;
      if (parity_bit !== exp_par) begin
        errors++;
        $display("FAIL shift_parity got %b exp %b", parity_bit, exp_par);
      end
      case (mode)
        0:       en = 1'b1;
        1:       en = 1'($urandom_range(0, 1));
        default: en = (c % 3) == 0;
      endcase
      enable = en;
      if (noise) begin
        load    = 1'($urandom_range(0, 1));
        data_in = DW'($urandom);
      end
      tick();
      if (en) void'(exp_q.pop_front());
      c++;
      if (c > 300) begin
        errors++;
        $display("FAIL shift_timeout frame did not finish in 300 cycles");
        exp_q.delete();
      end
    end
    load   = 1'b0;
    enable = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle busy=%b done=%b data_out=%b exp 0 1 0", busy, done, data_out);
    end
    checks++;
    if (parity_bit !== exp_par) begin
      errors++;
      $display("FAIL done_parity got %b exp %b", parity_bit, exp_par);
    end
  endtask

  task automatic end_frame();
    logic p;
    p = exp_par;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_clear done=%b busy=%b exp 0 0", done, busy);
    end
    checks++;
    if (parity_bit !== p) begin
      errors++;
      $display("FAIL parity_held got %b exp %b", parity_bit, p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in = '0; data_len = '0; msb_first = 1'b0; load = 1'b0; enable = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({data_out, busy, done, parity_bit} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {data_out, busy, done, parity_bit});
    end
  endtask

  task automatic test_lsb_full();
    start_frame(8'h55, 8, 1'b0);
    shift_frame(0, 1'b0);
    checks++;
    if (parity_bit !== 1'b0) begin
      errors++;
      $display("FAIL lsb55_parity got %b exp 0", parity_bit);
    end
    end_frame();
  endtask

  task automatic test_msb_short();
    start_frame(8'h13, 5, 1'b1);
    shift_frame(0, 1'b0);
    checks++;
    if (parity_bit !== 1'b1) begin
      errors++;
      $display("FAIL msb13_parity got %b exp 1", parity_bit);
    end
    end_frame();
  endtask

  task automatic test_pause();
    start_frame(8'hF0, 0, 1'b0);
    shift_frame(2, 1'b0);
    end_frame();
  endtask

  task automatic test_back_to_back();
    start_frame(8'hC3, 8, 1'b1);
    shift_frame(1, 1'b1);
    start_frame(8'h0F, 8, 1'b0);
    checks++;
    if (parity_bit !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start parity=%b busy=%b done=%b exp 0 1 0", parity_bit, busy, done);
    end
    shift_frame(0, 1'b1);
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'hB6, 8, 1'b0);
    enable = 1'b1;
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({data_out, busy, done, parity_bit} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got %b exp 0000", {data_out, busy, done, parity_bit});
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_nodone done=%b busy=%b cycle %0d", done, busy, i);
      end
    end
    enable = 1'b0;
    start_frame(8'hAA, 8, 1'b1);
    shift_frame(0, 1'b0);
    end_frame();
  endtask

  task automatic test_idle_enable();
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (data_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_enable data_out=%b done=%b busy=%b exp 000", data_out, done, busy);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    bit chained;
    chained = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if (!chained) tick();
      start_frame(DW'($urandom), int'($urandom_range(0, (1 << LW) - 1)), 1'($urandom_range(0, 1)));
      shift_frame(int'($urandom_range(0, 2)), 1'b1);
      chained = $urandom_range(0, 1) == 1;
      if (!chained) end_frame();
    end
    end_frame();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lsb_full();
    test_msb_short();
    test_pause();
    test_back_to_back();
    test_reset_mid_frame();
    test_idle_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
